// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus arbiter: FSM state encoding, hold counter
// width and the index-width helper used by the arbiter and its picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;

  localparam int HOLD_W = 8;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int rr_pick(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or after rr_ptr,
// found by rotating the request vector down by rr_ptr and priority-encoding it.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N = 4
)
(
  input  logic [N-1:0]          req,
  input  logic [rr_pick(N)-1:0] rr_ptr,
  output logic [N-1:0]          win,
  output logic [rr_pick(N)-1:0] win_idx,
  output logic                  any
);

  localparam int IW = rr_pick(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [N-1:0]  rot;
  logic [IW-1:0] offset;
  logic [IW:0]   sum;

  // Offset of the winner in the rotated vector, mapped back to an absolute index.
  always_comb begin
    rot = N'({req, req} >> rr_ptr);
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) offset = IW'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= N_W) sum = sum - N_W;
    win_idx = sum[IW-1:0];
    any = |req;
    win = '0;
    if (any) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared data bus: one-hot drive enables with
// dead turnaround cycles between owners and an optional per-grant hold limit.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 0
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          drive_en,
  output logic [rr_pick(N)-1:0] owner,
  output logic                  bus_busy,
  output logic                  timeout_err
);

  localparam int IW = rr_pick(N);
  localparam logic [IW-1:0]     LAST_IDX  = IW'(N - 1);
  localparam logic [1:0]        TURN_LAST = 2'(TURN_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t state, state_next;
  logic [1:0]        turn_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IW-1:0]     rr_ptr, ptr_next, pick_idx;
  logic [N-1:0]      mask, eligible, pick_win;
  logic              pick_any, do_grant, revoke;

  // Revoked masters stay out until they drop req; the owner never competes with itself.
  assign eligible = req & ~mask & ~gnt;

  rr_picker #(.N(N)) u_picker (
    .req     (eligible),
    .rr_ptr  (rr_ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign ptr_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    revoke     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = GRANT;
          do_grant   = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          state_next = TURN;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          state_next = TURN;
          revoke     = 1'b1;
        end
      end
      TURN: begin
        // Arbitrate in the last dead cycle so a waiting master loses no extra cycle.
        if (turn_cnt == TURN_LAST) begin
          if (pick_any) begin
            state_next = GRANT;
            do_grant   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      turn_cnt    <= '0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
      mask        <= '0;
      gnt         <= '0;
      drive_en    <= '0;
      owner       <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      timeout_err <= revoke;
      mask        <= (mask & req) | (revoke ? gnt : '0);
      if (state_next == TURN && state != TURN) begin
        turn_cnt <= '0;
      end else if (state == TURN) begin
        turn_cnt <= turn_cnt + 2'd1;
      end
      if (do_grant) begin
        gnt      <= pick_win;
        drive_en <= pick_win;
        owner    <= pick_idx;
        bus_busy <= 1'b1;
        hold_cnt <= '0;
        rr_ptr   <= ptr_next;
      end else begin
        if (state_next != GRANT) begin
          gnt      <= '0;
          drive_en <= '0;
          bus_busy <= 1'b0;
        end
        if (state == GRANT && hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared 16-bit internal data bus. Each bus master drives the bus through its own `tristate_buffer`. This block decides which master may drive and produces the one-hot drive enables for the buffer `T` inputs. It guarantees at most one driver per cycle and inserts dead cycles between owners so buffers never contend. It also enforces an optional maximum hold time per grant.

## Interface
- `N`, default 4: number of requesters/bus masters (2..8).
- `TURN_CYCLES`, default 1: dead cycles (no driver) between consecutive owners (1..3).
- `MAX_HOLD`, default 0: maximum consecutive GRANT cycles per owner; 0 disables the limit (otherwise 1..255).

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N: request per master; level, held high for the whole transfer.
- `gnt` output N: one-hot grant, registered.
- `drive_en` output N: one-hot; connects directly to the `T` of each master's `tristate_buffer`. High means that master drives the bus.
- `owner` output $clog2(N): index of the current owner; valid only while `bus_busy`.
- `bus_busy` output 1: high while any grant is active.
- `timeout_err` output 1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- FSM states:
  - IDLE: no owner, all enables low.
  - GRANT: one owner drives.
  - TURN: dead cycles after a release.
- IDLE → GRANT:
  - Taken when any eligible `req` bit is high.
  - Winner = first eligible requester at or after `rr_ptr` (modulo N, increasing index).
- GRANT → TURN:
  - Taken when the owner's `req` is low (normal release), or when `hold_cnt` reaches `MAX_HOLD` (revoke).
  - Other requests never pre-empt the owner.
- TURN → GRANT or IDLE:
  - Taken after `TURN_CYCLES` cycles.
  - Arbitration is evaluated in the last TURN cycle, so a waiting master is granted with no extra idle cycle.
- `rr_ptr` is set to (winner+1) mod N on every grant. Reset value is 0, so requester 0 has the highest priority out of reset.
- `hold_cnt`:
  - Width is 8 bits.
  - Cleared on entering GRANT.
  - Increments each GRANT cycle; saturates.
- Revoke handling:
  - `timeout_err` pulses in the first TURN cycle.
  - The revoked master is marked ineligible (`mask` bit) until its `req` is sampled low.
  - A master that never drops `req` is never regranted.
- `gnt` and `drive_en` are identical bit patterns, kept as separate ports for fan-out. Both are zero outside GRANT.
- Requests from a master that is already the owner are ignored for arbitration.
- Reset values:
  - `gnt` = 0, `drive_en` = 0, `owner` = 0, `bus_busy` = 0, `timeout_err` = 0.
  - FSM = IDLE, `rr_ptr` = 0, `mask` = 0, `hold_cnt` = 0.

## Timing
- All outputs are registered; no combinational path from `req` to any output.
- Grant latency from idle: `req` first sampled high at edge k → `gnt`/`drive_en` high after edge k (visible in cycle k+1).
- Release: owner `req` sampled low at edge m → `drive_en` low in cycle m+1. Next owner is driving in cycle m+1+`TURN_CYCLES`.
- Revoke: with `MAX_HOLD`=M, owner drives for exactly M cycles. Then `drive_en` is low, with `timeout_err` high for one cycle.
- Simultaneous release and a new request in the same cycle: the new request is served after TURN, never in the release cycle.
- All N requesting continuously, each releasing after one cycle: grants rotate 0,1,2,3,0… Any requester waits at most (N−1) × (max hold + `TURN_CYCLES`) cycles.
- Reset asserted mid-GRANT: `drive_en` is 0 in the cycle after the reset edge, and all state returns to reset values. There is no TURN after reset, because no buffer drives.
- Invariant checked every cycle: $onehot0(`drive_en`). Also, there is no cycle in which `drive_en` changes directly from one nonzero value to a different nonzero value.

## Structure
- Package `bus_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, GRANT, TURN};
  - the `HOLD_W` = 8 constant;
  - the `rr_pick` index-width helper.
- Sub-module `rr_picker` is purely combinational. Inputs are `req` & ~`mask` and `rr_ptr`. Outputs are one-hot `win`, `win_idx`, `any`. It is implemented as a double-width rotate and a priority encode.
- Top level holds the FSM, turn counter, hold counter, mask, pointer and output registers.
- Target size: about 200 lines of RTL.

## Test plan
- Reset defaults: assert `rst` 2 cycles with `req`=4'b1111 → all outputs 0. After release, `gnt`=4'b0001 one cycle later.
- Simple transfer: `req`[2] high for 5 cycles, N=4, `TURN_CYCLES`=1 → `drive_en`=4'b0100 for exactly 5 cycles, starting one cycle after the request. `owner`=2 and `bus_busy`=1 during the grant.
- Round-robin fairness: all four request continuously, each dropping `req` for one cycle after a 3-cycle grant → grant order 0,1,2,3,0. There is exactly one zero-`drive_en` cycle between owners.
- Hold limit: `MAX_HOLD`=4, `req`[1] held high for 20 cycles and `req`[3] high → master 1 drives 4 cycles, then `timeout_err` pulses and master 3 is granted. Master 1 is not regranted until its `req` drops and rises again.
- Reset mid-grant: assert `rst` on the 3rd cycle of a grant to master 0 → `drive_en`=0 the next cycle and `rr_ptr` returns to 0.
- Random stress: 10k cycles of random `req`, N=8, `TURN_CYCLES`=2 → the onehot0 and no-direct-handover invariants hold every cycle, and no requester starves beyond the bound.
